// File: rtl/obstacle_pkg.sv
// Shared types and constants for the obstacle engine.
package obstacle_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  // Screen coordinates, plus one spare bit so sums of coordinate and box size never wrap.
  localparam int CW = 10;
  localparam int OW = 11;

  // Feedback taps for x^10 + x^7 + 1 (bit indices into the shift register).
  localparam int LFSR_TAP_HI = 9;
  localparam int LFSR_TAP_LO = 6;

endpackage

// File: rtl/lfsr10.sv
// Seeded 10-bit Fibonacci LFSR with an enable.
module lfsr10
  import obstacle_pkg::*;
#(
  parameter logic [CW-1:0] SEED = 10'h1A5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] q
);

  // Shift left and feed the XOR of the two taps into bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= SEED;
    else if (en) q <= {q[CW-2:0], q[LFSR_TAP_HI] ^ q[LFSR_TAP_LO]};
  end

endmodule

// File: rtl/obstacle_field.sv
// Falling-obstacle engine: spawning, per-frame motion, collision, score, speed and game state.
module obstacle_field
  import obstacle_pkg::*;
#(
  parameter int N_OBS         = 4,
  parameter int SCREEN_W      = 640,
  parameter int SCREEN_H      = 480,
  parameter int OBS_W         = 32,
  parameter int OBS_H         = 32,
  parameter int PLY_W         = 32,
  parameter int PLY_H         = 32,
  parameter int SPAWN_FRAMES  = 60,
  parameter int STEP_INIT     = 2,
  parameter int STEP_MAX      = 8,
  parameter int SPEEDUP_EVERY = 10,
  parameter logic [CW-1:0] LFSR_SEED = 10'h1A5
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  vsync,
  input  logic                  start,
  input  logic [CW-1:0]         player_x,
  input  logic [CW-1:0]         player_y,
  output logic [CW*N_OBS-1:0]   obs_x,
  output logic [CW*N_OBS-1:0]   obs_y,
  output logic [N_OBS-1:0]      obs_active,
  output logic [6:0]            score,
  output logic [6:0]            max_score,
  output logic [3:0]            step,
  output logic                  game_over,
  output logic                  hit
);

  localparam int SPAN = SCREEN_W - OBS_W;

  state_t                       state_q, state_d;
  logic [2:0]                   vs_sync;
  logic                         tick, ptick, chk_q, collide, new_game;
  logic [N_OBS-1:0]             act_q, act_d, exit_v, hit_v;
  logic [N_OBS-1:0][CW-1:0]     ox_q, oy_q, ox_d, oy_d;
  logic [N_OBS-1:0][OW-1:0]     ysum;
  logic [OW-1:0]                px_e, py_e;
  logic [15:0]                  timer_q;
  logic                         spawn_now, placed;
  logic [CW-1:0]                rnd, spawn_x;
  logic [7:0]                   n_scored, score_sum, spd_sum, spd_cnt_d, step_sum, spd_cnt_q;
  logic [6:0]                   score_q, score_d, max_q;
  logic [3:0]                   step_q, step_d;

  assign obs_x      = ox_q;
  assign obs_y      = oy_q;
  assign obs_active = act_q;
  assign score      = score_q;
  assign max_score  = max_q;
  assign step       = step_q;
  assign game_over  = (state_q == S_OVER);

  lfsr10 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (CLOCK_50),
    .rst_n (reset),
    .en    (1'b1),
    .q     (rnd)
  );

  // Two-flop synchroniser on vsync plus one history flop for rising-edge detect.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) vs_sync <= '0;
    else        vs_sync <= {vs_sync[1:0], vsync};
  end

  assign tick      = vs_sync[1] & ~vs_sync[2];
  assign ptick     = tick && (state_q == S_PLAY);
  assign new_game  = start && (state_q != S_PLAY);
  assign collide   = chk_q && (state_q == S_PLAY) && (|hit_v);
  assign spawn_now = (timer_q == 16'(SPAWN_FRAMES - 1));
  assign spawn_x   = (rnd >= CW'(SPAN)) ? rnd - CW'(SPAN) : rnd;
  assign px_e      = {1'b0, player_x};
  assign py_e      = {1'b0, player_y};

  for (genvar g = 0; g < N_OBS; g++) begin : g_slot
    logic [OW-1:0] ox_e, oy_e;
    assign ox_e      = {1'b0, ox_q[g]};
    assign oy_e      = {1'b0, oy_q[g]};
    assign ysum[g]   = oy_e + OW'(step_q);
    assign exit_v[g] = act_q[g] && (ysum[g] >= OW'(SCREEN_H));
    assign hit_v[g]  = act_q[g]
                    && (ox_e < px_e + OW'(PLY_W)) && (px_e < ox_e + OW'(OBS_W))
                    && (oy_e < py_e + OW'(PLY_H)) && (py_e < oy_e + OW'(OBS_H));
  end

  assign n_scored  = 8'($countones(exit_v));
  assign score_sum = {1'b0, score_q} + n_scored;
  assign score_d   = (score_sum > 8'd127) ? 7'd127 : score_sum[6:0];
  // Several exits in one frame can cross more than one speed-up boundary.
  assign spd_sum   = spd_cnt_q + n_scored;
  assign spd_cnt_d = spd_sum % 8'(SPEEDUP_EVERY);
  assign step_sum  = {4'b0, step_q} + (spd_sum / 8'(SPEEDUP_EVERY));
  assign step_d    = (step_sum > 8'(STEP_MAX)) ? 4'(STEP_MAX) : step_sum[3:0];

  // Per-frame slot update: advance/retire active slots, then spawn into the lowest free slot.
  always_comb begin
    act_d  = act_q & ~exit_v;
    ox_d   = ox_q;
    oy_d   = oy_q;
    placed = 1'b0;
    for (int i = 0; i < N_OBS; i++) begin
      if (act_q[i]) oy_d[i] = exit_v[i] ? '0 : ysum[i][CW-1:0];
      if (spawn_now && !placed && !act_d[i]) begin
        act_d[i] = 1'b1;
        ox_d[i]  = spawn_x;
        oy_d[i]  = '0;
        placed   = 1'b1;
      end
    end
  end

  // Game state register.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: start leaves IDLE/OVER, a detected collision ends play.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_OVER: if (start)   state_d = S_PLAY;
      S_PLAY:         if (collide) state_d = S_OVER;
      default:                     state_d = S_IDLE;
    endcase
  end

  // Slot, score, speed and spawn-timer state: cleared on a new game, advanced on play ticks.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      act_q     <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      score_q   <= '0;
      step_q    <= 4'(STEP_INIT);
      spd_cnt_q <= '0;
      timer_q   <= '0;
    end else if (new_game) begin
      act_q     <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      score_q   <= '0;
      step_q    <= 4'(STEP_INIT);
      spd_cnt_q <= '0;
      timer_q   <= '0;
    end else if (ptick) begin
      act_q     <= act_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      score_q   <= score_d;
      step_q    <= step_d;
      spd_cnt_q <= spd_cnt_d;
      timer_q   <= spawn_now ? '0 : timer_q + 16'd1;
    end
  end

  // Collision is judged the cycle after a play tick, on the freshly updated positions.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      chk_q <= 1'b0;
      hit   <= 1'b0;
      max_q <= '0;
    end else begin
      chk_q <= ptick;
      hit   <= collide;
      if (collide && (score_q > max_q)) max_q <= score_q;
    end
  end

endmodule

// File: doc/obstacle_field.md
# obstacle_field

Multi-channel obstacle engine for the dodge game: owns up to `N_OBS` falling obstacles, spawns them at pseudo-random x positions on a frame-based timer, moves them once per video frame, and detects collisions against the player box. It also keeps score and high score, speeds the game up as the score grows, and runs the IDLE/PLAY/OVER game state. It sits between the player controller and the sprite/colour mux in the top level, clocked from `CLOCK_50`, with frame pacing taken from `VGA_VS`.

## Interface
- `N_OBS`, 4: number of obstacle slots (1..8)
- `SCREEN_W`, 640: visible width in pixels
- `SCREEN_H`, 480: visible height in pixels
- `OBS_W` / `OBS_H`, 32 / 32: obstacle box size
- `PLY_W` / `PLY_H`, 32 / 32: player box size
- `SPAWN_FRAMES`, 60: frames between spawn attempts (≥1)
- `STEP_INIT`, 2: initial fall speed in pixels/frame
- `STEP_MAX`, 8: speed ceiling
- `SPEEDUP_EVERY`, 10: scored obstacles per +1 speed step
- `LFSR_SEED`, 10'h1A5: LFSR reset value (must be nonzero)

Ports:
- `CLOCK_50` in 1: system clock
- `reset` in 1: asynchronous, active-low reset
- `vsync` in 1: `VGA_VS`, asynchronous to the logic; synchronised internally
- `start` in 1: one-cycle start pulse
- `player_x`, `player_y` in 10 each: player top-left corner
- `obs_x`, `obs_y` out `10*N_OBS` each: slot i occupies bits `[10i+9:10i]`
- `obs_active` out `N_OBS`: slot i is visible
- `score`, `max_score` out 7 each
- `step` out 4: current fall speed
- `game_over` out 1: high in OVER
- `hit` out 1: one-cycle pulse when a collision is detected

## Operation
- States: IDLE → (start) PLAY → (collision) OVER → (start) PLAY.
  - On entry to PLAY: all slots are cleared, `score`=0, `step`=`STEP_INIT`, spawn timer=0.
  - `max_score` is kept across games.
- Frame tick: `vsync` passes through a 2-flop synchroniser; the tick is a one-cycle pulse on its rising edge (end of sync pulse). All game updates happen only on ticks, and only in PLAY.
- Per tick, for each active slot:
  - `y` += `step` (11-bit sum).
  - If the sum ≥ `SCREEN_H`, the slot deactivates and counts as scored.
- Scoring:
  - `score` += number of slots scored in that tick, saturating at 127.
  - The speed-up counter accumulates the same count. Each time it reaches `SPEEDUP_EVERY`, it wraps and `step` increments, saturating at `STEP_MAX`.
- Spawn timer:
  - Counts ticks. At `SPAWN_FRAMES-1` it resets to 0 and attempts a spawn.
  - A spawn goes into the lowest-index inactive slot, with `y`=0 and `x` = LFSR value reduced into `[0, SCREEN_W-OBS_W)` by one conditional subtraction of (`SCREEN_W-OBS_W`).
  - If every slot is active, the spawn is dropped and the timer still resets.
  - A slot freed in the same tick may be reused in that tick.
- LFSR: 10-bit Fibonacci, polynomial x^10+x^7+1. It advances every clock in every state, so spawn positions depend on player timing.
- Collision:
  - Checked one cycle after the tick, on the updated positions.
  - Per slot, AABB test: `ox < px+PLY_W && px < ox+OBS_W && oy < py+PLY_H && py < oy+OBS_H`, using 11-bit arithmetic.
  - Any active hit causes: `hit` pulse, transition to OVER, and `max_score` ← max(`max_score`, `score`).
  - `score` already includes any exits from that same tick.
- OVER: obstacles freeze and stay visible; ticks are ignored.
- `start` in PLAY is ignored.

## Timing
- Reset values: all slots inactive, `obs_x`/`obs_y`=0, `score`=`max_score`=0, `step`=`STEP_INIT`, `game_over`=0, `hit`=0, state IDLE, LFSR=`LFSR_SEED`.
- Latency:
  - `vsync` rising edge to tick: 2–3 clocks.
  - Tick to positions/score updated: 1 clock.
  - Collision result (`hit`, `game_over`): 1 clock after that.
- `start` → PLAY and cleared slots: 1 clock.
- Reset asserted mid-game returns everything, including `max_score`, to reset values immediately.

## Structure
- Package `obstacle_pkg` holds:
  - state enum (IDLE/PLAY/OVER)
  - coordinate width (10) and overflow width (11)
  - LFSR tap constants
- Sub-module `lfsr10`: seeded 10-bit LFSR with an enable; free-running here.
- The synchroniser/edge detector stays inline.

## Test plan
- Reset, then `start`, with N_OBS=4, SPAWN_FRAMES=3 and player far away → slot 0 activates with `y`=0 after the 3rd tick; `x` < 608.
- Keep ticking → `y` increases by 2 per tick; at `y`=478 the next tick deactivates the slot and `score` becomes 1.
- Set SPEEDUP_EVERY=2 and let 2 obstacles exit → `step` becomes 3. Continue until saturation → `step` holds at 8.
- Keep all 4 slots active at spawn time → no spawn, all `obs_active` stay 1111, timer resets.
- Place the player at (x_obs, 100) and let the obstacle reach `y`=70 → `hit` pulses once, `game_over`=1, `max_score`=`score`. Further ticks leave `y` unchanged.
- Assert `reset` (low) mid-PLAY → all outputs return to reset values asynchronously. Then `start` → new game with `score` 0.
